// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;
   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshakes plus the live serial difference stream.
interface serial_subtractor_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             serial_valid;
   logic             serial_bit;

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, serial_valid, serial_bit
   );

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, serial_valid, serial_bit
   );
endinterface

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = x - y - br, bo = borrow out.
module full_subtractor_cell (
   input  logic i_x,
   input  logic i_y,
   input  logic i_br,
   output logic o_d,
   output logic o_bo
);
   assign o_d  = i_x ^ i_y ^ i_br;
   assign o_bo = (~i_x & i_y) | (~(i_x ^ i_y) & i_br);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin, LSB first, one bit per clock through a single cell.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter  int WIDTH = WIDTH_DEF,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input logic          clk,
   input logic          rst_n,
   serial_subtractor_if.slave bus
);
   state_t           r_state;
   logic [WIDTH-1:0] r_sh_a, r_sh_b, r_res, r_diff;
   logic [CNT_W-1:0] r_cnt;
   logic             r_borrow, r_bout;
   logic             r_in_ready, r_out_valid, r_serial_valid;
   logic             w_d, w_bo;

   full_subtractor_cell u_cell (
      .i_x  (r_sh_a[0]),
      .i_y  (r_sh_b[0]),
      .i_br (r_borrow),
      .o_d  (w_d),
      .o_bo (w_bo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_sh_a         <= '0;
         r_sh_b         <= '0;
         r_res          <= '0;
         r_diff         <= '0;
         r_cnt          <= '0;
         r_borrow       <= 1'b0;
         r_bout         <= 1'b0;
         r_in_ready     <= 1'b1;
         r_out_valid    <= 1'b0;
         r_serial_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_sh_a         <= bus.a;
                  r_sh_b         <= bus.b;
                  r_borrow       <= bus.bin;
                  r_cnt          <= '0;
                  r_state        <= RUN;
                  r_in_ready     <= 1'b0;
                  r_serial_valid <= 1'b1;
               end
            end
            RUN: begin
               r_borrow <= w_bo;
               r_sh_a   <= r_sh_a >> 1;
               r_sh_b   <= r_sh_b >> 1;
               r_res    <= {w_d, r_res[WIDTH-1:1]};
               r_cnt    <= r_cnt + 1'b1;
               // Final bit: publish the parallel result so diff stays frozen during RUN.
               if (r_cnt == CNT_W'(WIDTH-1)) begin
                  r_state        <= DONE;
                  r_cnt          <= '0;
                  r_bout         <= w_bo;
                  r_diff         <= {w_d, r_res[WIDTH-1:1]};
                  r_out_valid    <= 1'b1;
                  r_serial_valid <= 1'b0;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state        <= IDLE;
               r_in_ready     <= 1'b1;
               r_out_valid    <= 1'b0;
               r_serial_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready     = r_in_ready;
   assign bus.out_valid    = r_out_valid;
   assign bus.diff         = r_diff;
   assign bus.bout         = r_bout;
   assign bus.serial_valid = r_serial_valid;
   assign bus.serial_bit   = r_serial_valid & w_d;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of the serial subtractor with immediate assertions.
module tb_serial_subtractor;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts and ends at a negedge with the DUT in IDLE.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [W-1:0] exp_d, input logic exp_bo,
                         input bit hold, input logic [W-1:0] na, input logic [W-1:0] nb,
                         input int bp, input bit chk_ser);
      int cyc;
      bus.in_valid = 1'b1;
      bus.a = a;
      bus.b = b;
      bus.bin = bin;
      @(posedge clk);
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            if (hold) begin
               bus.a = na;
               bus.b = nb;
            end else begin
               bus.in_valid = 1'b0;
            end
            chk("in_ready_run", bus.in_ready, 0);
         end
         if (bus.out_valid) break;
         if (chk_ser) begin
            chk("serial_valid", bus.serial_valid, 1);
            chk($sformatf("serial_bit%0d", cyc - 1), bus.serial_bit, exp_d[cyc-1]);
         end
         if (cyc > 3 * W) break;
      end
      chk("latency", cyc, W + 1);
      chk("diff", bus.diff, exp_d);
      chk("bout", bus.bout, exp_bo);
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_diff", bus.diff, exp_d);
         chk("bp_bout", bus.bout, exp_bo);
         chk("bp_in_ready", bus.in_ready, 0);
      end
      if (chk_ser) chk("serial_valid_done", bus.serial_valid, 0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("idle_out_valid", bus.out_valid, 0);
      chk("idle_in_ready", bus.in_ready, 1);
      chk("idle_diff_hold", bus.diff, exp_d);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [W:0] ref_v;
      logic [W-1:0] ra, rb;
      logic rbin;

      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.bin = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_diff", bus.diff, 0);
      chk("rst_bout", bus.bout, 0);
      chk("rst_serial_valid", bus.serial_valid, 0);
      chk("rst_serial_bit", bus.serial_bit, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 0x35 - 0x12 = 0x23, serial stream 1,1,0,0,0,1,0,0
      run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 0, 8'h00, 8'h00, 0, 1);
      run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0, 8'h00, 8'h00, 0, 1);
      run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 0, 8'h00, 8'h00, 0, 1);
      // Backpressure for 5 cycles in DONE
      run_op(8'h5A, 8'hA5, 1'b0, 8'hB5, 1'b1, 0, 8'h00, 8'h00, 5, 0);

      // in_valid held high; operands change mid-RUN must not leak in
      run_op(8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1, 8'h01, 8'h02, 0, 0);
      run_op(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 0, 8'h00, 8'h00, 0, 0);

      // Reset at cnt==3 of RUN
      bus.in_valid = 1'b1;
      bus.a = 8'h77;
      bus.b = 8'h11;
      bus.bin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_serial_valid", bus.serial_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", bus.in_ready, 1);
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_diff", bus.diff, 0);
      chk("mid_rst_bout", bus.bout, 0);
      chk("mid_rst_serial_valid", bus.serial_valid, 0);
      chk("mid_rst_serial_bit", bus.serial_bit, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 0, 8'h00, 8'h00, 0, 1);

      // Random regression against an unsigned 9-bit reference
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         rbin = 1'($urandom_range(0, 1));
         ref_v = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
         run_op(ra, rb, rbin, ref_v[W-1:0], ref_v[W], 0, 8'h00, 8'h00, 0, (i < 20));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
